// File: rtl/cm163_pkg.sv
// Shared types and helpers for the CM163 cascadable counter.
package cm163_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef logic [SLICE_W-1:0] slice_t;

  // Terminal-count test: true when a slice holds all ones.
  function automatic logic slice_tc(input slice_t s);
    return &s;
  endfunction

endpackage

// File: rtl/cm163_slice.sv
// One 4-bit counter slice. The top decodes priority; the slice applies clear > load > increment.
module cm163_slice
  import cm163_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   cin_en,
  input  logic   clr,
  input  logic   load,
  input  slice_t d,
  output slice_t q,
  output logic   tc
);

  slice_t q_q;
  slice_t q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = d;
    end else if (cin_en) begin
      q_d = q_q + slice_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign tc = slice_tc(q_q);

endmodule

// File: rtl/cm163_seq_counter.sv
// 74163-style counter built from cascaded 4-bit slices, with rco, wrap pulse and sticky overflow.
module cm163_seq_counter
  import cm163_pkg::*;
#(
  parameter int unsigned STAGES = 1
) (
  input  logic                        clk_pad,
  input  logic                        rst_n_pad,
  input  logic                        clr_n_pad,
  input  logic                        load_n_pad,
  input  logic                        enp_pad,
  input  logic                        ent_pad,
  input  logic [SLICE_W*STAGES-1:0]   d_pad,
  output logic [SLICE_W*STAGES-1:0]   q_pad,
  output logic                        rco_pad,
  output logic                        wrap_pad,
  output logic                        ovf_pad
);

  localparam int unsigned WIDTH = SLICE_W * STAGES;

  logic              clr_c;
  logic              load_c;
  logic              inc_c;
  logic [STAGES-1:0] en_c;
  logic [STAGES-1:0] tc_c;
  logic              all_ones_c;
  logic              wrap_q;
  logic              wrap_d;
  logic              ovf_q;
  logic              ovf_d;
  logic [WIDTH-1:0]  q_c;

  assign clr_c      = ~clr_n_pad;
  assign load_c     = clr_n_pad & ~load_n_pad;
  assign inc_c      = clr_n_pad & load_n_pad & enp_pad & ent_pad;
  assign all_ones_c = &tc_c;

  // Carry chain: a slice counts only when every lower slice is at terminal count.
  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    if (i == 0) begin : g_first
      assign en_c[i] = inc_c;
    end else begin : g_next
      assign en_c[i] = en_c[i-1] & tc_c[i-1];
    end

    cm163_slice u_slice (
      .clk    (clk_pad),
      .rst_n  (rst_n_pad),
      .cin_en (en_c[i]),
      .clr    (clr_c),
      .load   (load_c),
      .d      (d_pad[i*SLICE_W +: SLICE_W]),
      .q      (q_c[i*SLICE_W +: SLICE_W]),
      .tc     (tc_c[i])
    );
  end

  always_comb begin
    wrap_d = inc_c & all_ones_c;
    ovf_d  = ovf_q;
    if (clr_c) begin
      ovf_d = 1'b0;
    end else if (wrap_d) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q_pad    = q_c;
  assign rco_pad  = ent_pad & all_ones_c;
  assign wrap_pad = wrap_q;
  assign ovf_pad  = ovf_q;

endmodule

// File: tb/tb_cm163_seq_counter.sv
// Randomized and directed checks of cm163_seq_counter (1- and 2-slice builds) against a behavioural model.
module tb_cm163_seq_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_n = 1'b1;
  logic       load_n = 1'b1;
  logic       enp = 1'b0;
  logic       ent = 1'b0;
  logic [3:0] d1 = '0;
  logic [7:0] d2 = '0;
  logic [3:0] q1;
  logic [7:0] q2;
  logic       rco1, rco2, wrap1, wrap2, ovf1, ovf2;

  int n_chk  = 0;
  int n_fail = 0;

  int unsigned m1_q = 0, m2_q = 0;
  bit          m1_w = 0, m2_w = 0, m1_o = 0, m2_o = 0;

  always #5 clk = ~clk;

  cm163_seq_counter #(.STAGES(1)) u1 (
    .clk_pad(clk), .rst_n_pad(rst_n), .clr_n_pad(clr_n), .load_n_pad(load_n),
    .enp_pad(enp), .ent_pad(ent), .d_pad(d1), .q_pad(q1), .rco_pad(rco1),
    .wrap_pad(wrap1), .ovf_pad(ovf1)
  );

  cm163_seq_counter #(.STAGES(2)) u2 (
    .clk_pad(clk), .rst_n_pad(rst_n), .clr_n_pad(clr_n), .load_n_pad(load_n),
    .enp_pad(enp), .ent_pad(ent), .d_pad(d2), .q_pad(q2), .rco_pad(rco2),
    .wrap_pad(wrap2), .ovf_pad(ovf2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural step: first matching rule of clear, load, count, hold.
  function automatic void mstep(input int unsigned width, input int unsigned d,
                                inout int unsigned q, inout bit wr, inout bit ov);
    int unsigned modv;
    modv = 1 << width;
    wr = 1'b0;
    if (!clr_n) begin
      q  = 0;
      ov = 1'b0;
    end else if (!load_n) begin
      q = d;
    end else if (enp && ent) begin
      if (q == modv - 1) begin
        wr = 1'b1;
        ov = 1'b1;
      end
      q = (q + 1) % modv;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_q = 0; m1_w = 0; m1_o = 0;
      m2_q = 0; m2_w = 0; m2_o = 0;
    end else begin
      mstep(4, 32'(d1), m1_q, m1_w, m1_o);
      mstep(8, 32'(d2), m2_q, m2_w, m2_o);
    end
  end

  always @(negedge clk) begin
    chk("q1",    32'(q1),    m1_q);
    chk("rco1",  32'(rco1),  32'(ent && (m1_q == 15)));
    chk("wrap1", 32'(wrap1), 32'(m1_w));
    chk("ovf1",  32'(ovf1),  32'(m1_o));
    chk("q2",    32'(q2),    m2_q);
    chk("rco2",  32'(rco2),  32'(ent && (m2_q == 255)));
    chk("wrap2", 32'(wrap2), 32'(m2_w));
    chk("ovf2",  32'(ovf2),  32'(m2_o));
  end

  // Apply controls, take one edge, land 2 time units after it.
  task automatic cyc(input bit c, input bit l, input bit p, input bit t,
                     input logic [3:0] a, input logic [7:0] b);
    clr_n = c; load_n = l; enp = p; ent = t; d1 = a; d2 = b;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #12;
    chk("rst_q1", 32'(q1), 32'h0);
    chk("rst_rco1", 32'(rco1), 32'h0);
    chk("rst_wrap2", 32'(wrap2), 32'h0);
    chk("rst_ovf2", 32'(ovf2), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Count D,E,F,0 on one slice; 0F -> 10 on two slices.
    cyc(1, 0, 0, 0, 4'hD, 8'h0F);
    chk("ld_q1", 32'(q1), 32'hD);
    chk("ld_rco1", 32'(rco1), 32'h0);
    cyc(1, 1, 1, 1, 4'h0, 8'h00);
    chk("cnt_q1_e", 32'(q1), 32'hE);
    chk("casc_q2_10", 32'(q2), 32'h10);
    cyc(1, 1, 1, 1, 4'h0, 8'h00);
    chk("cnt_q1_f", 32'(q1), 32'hF);
    chk("cnt_rco1_f", 32'(rco1), 32'h1);
    cyc(1, 1, 1, 1, 4'h0, 8'h00);
    chk("wrap_q1_0", 32'(q1), 32'h0);
    chk("wrap_pulse1", 32'(wrap1), 32'h1);
    chk("wrap_ovf1", 32'(ovf1), 32'h1);
    chk("wrap_rco1", 32'(rco1), 32'h0);
    cyc(1, 1, 0, 1, 4'h0, 8'h00);
    chk("wrap1_drop", 32'(wrap1), 32'h0);
    chk("ovf1_sticky", 32'(ovf1), 32'h1);

    // Clear beats load; then a plain load.
    cyc(0, 0, 1, 1, 4'hA, 8'hAA);
    chk("prio_q1", 32'(q1), 32'h0);
    chk("prio_ovf1", 32'(ovf1), 32'h0);
    cyc(1, 0, 1, 1, 4'hA, 8'hAA);
    chk("load_q1_a", 32'(q1), 32'hA);
    chk("load_q2_aa", 32'(q2), 32'hAA);

    // Load all ones with enables low: no wrap, no overflow; rco tracks ent.
    cyc(1, 0, 0, 0, 4'hF, 8'hFF);
    chk("ldf_wrap1", 32'(wrap1), 32'h0);
    chk("ldf_ovf1", 32'(ovf1), 32'h0);
    chk("ldf_rco1_lo", 32'(rco1), 32'h0);
    ent = 1'b1;
    #1;
    chk("ldf_rco1_hi", 32'(rco1), 32'h1);
    chk("ldf_rco2_hi", 32'(rco2), 32'h1);
    cyc(1, 1, 0, 1, 4'h0, 8'h00);
    chk("hold_q1_f", 32'(q1), 32'hF);
    chk("hold_rco1", 32'(rco1), 32'h1);
    ent = 1'b0;
    #1;
    chk("ent0_rco1", 32'(rco1), 32'h0);
    chk("ent0_q1", 32'(q1), 32'hF);

    // Two-slice wrap FF -> 00.
    cyc(1, 1, 1, 1, 4'h0, 8'h00);
    chk("casc_q2_00", 32'(q2), 32'h00);
    chk("casc_wrap2", 32'(wrap2), 32'h1);
    chk("casc_ovf2", 32'(ovf2), 32'h1);
    cyc(1, 1, 0, 0, 4'h0, 8'h00);
    chk("casc_wrap2_one", 32'(wrap2), 32'h0);
    chk("casc_ovf2_stk", 32'(ovf2), 32'h1);

    // Asynchronous reset mid-count at 7.
    cyc(1, 0, 0, 0, 4'h7, 8'h77);
    cyc(1, 1, 1, 1, 4'h0, 8'h00);
    chk("pre_rst_q1", 32'(q1), 32'h8);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_q1", 32'(q1), 32'h0);
    chk("arst_ovf2", 32'(ovf2), 32'h0);
    chk("arst_wrap1", 32'(wrap1), 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic, biased towards counting and near-terminal loads.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] a;
      logic [7:0] b;
      a = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      b = ($urandom_range(0, 2) == 0) ? 8'hFF - 8'($urandom_range(0, 2)) : 8'($urandom);
      cyc(($urandom_range(0, 40) != 0), ($urandom_range(0, 10) != 0),
          ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0), a, b);
      if ($urandom_range(0, 500) == 0) begin
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
